// File: rtl/hilo_unit.sv
// HI/LO register file and DIVU sequencer for a MIPS-style pipeline.
// Latency: MTHI/MTLO update on the next edge; a divide result lands on hi/lo
//   two edges after the divider's stop rising edge is sampled.
// Backpressure: stall is raised for any HI/LO-related instruction while a
//   divide is in flight; the held instruction takes effect once stall drops.
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   div_start         DIVU issued this cycle; div_b_zero flags a zero divisor
//   div_signal        level drive to the divider, high only while BUSY
//   div_stop          divider done flag; div_data = {remainder, quotient}
//   mthi/mtlo, wdata  write HI/LO
//   mfhi/mflo, rdata  read HI/LO (combinational, with same-cycle forwarding)
//   stall             freeze IF/ID/EX this cycle
//   hi, lo            architectural HI and LO
//   err_pulse         one-cycle pulse on divide-by-zero or divider timeout
module hilo_unit #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_start,
  input  logic        div_b_zero,
  output logic        div_signal,
  input  logic        div_stop,
  input  logic [63:0] div_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err_pulse
);

  // Counter must hold values up to TIMEOUT.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   hold_q, hold_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          err_q, err_d;
  logic          stop_prev_q;

  logic          start_ok;
  logic          stop_rise;
  logic          timed_out;

  assign start_ok  = div_start && !div_b_zero;
  // Only a fresh 0->1 edge counts, and never on the first BUSY cycle: a stop
  // flag left high by the previous divide must not be taken as this result.
  assign stop_rise = div_stop && !stop_prev_q && (cnt_q != '0);
  // cnt_q counts BUSY cycles already completed, so this is the last one.
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = BUSY;
      end
      BUSY: begin
        if (stop_rise)      state_d = DONE;
        else if (timed_out) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Gating with reset keeps div_signal and stall low for the whole reset
  // cycle, even before the state register has been forced back to IDLE.
  always_comb begin
    div_signal = reset && (state_q == BUSY);
    stall      = reset && (state_q != IDLE) &&
                 (div_start || mthi || mtlo || mfhi || mflo);
    rdata      = '0;
    if (mfhi) begin
      rdata = mthi ? wdata : hi_q;
    end else if (mflo) begin
      rdata = mtlo ? wdata : lo_q;
    end
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Moves and a divide may issue together; the move lands now and the
        // divide result overwrites it later in DONE.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (div_start) begin
          if (div_b_zero) err_d = 1'b1;
          else            cnt_d = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (stop_rise)      hold_d = div_data;
        else if (timed_out) err_d  = 1'b1;
      end
      DONE: begin
        hi_d = hold_q[63:32];
        lo_d = hold_q[31:0];
      end
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      hold_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      stop_prev_q <= div_stop;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios plus randomized divides and moves.
// Divide outcomes are queued at issue time; a monitor pops them on err_pulse
// or one cycle after div_signal falls, and compares hi/lo.
module tb_hilo_unit;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start, div_b_zero, div_signal, div_stop;
  logic [63:0] div_data;
  logic        mthi, mtlo, mfhi, mflo;
  logic [31:0] wdata, rdata, hi, lo;
  logic        stall, err_pulse;

  always #5 clk = ~clk;

  hilo_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .div_start(div_start), .div_b_zero(div_b_zero),
    .div_signal(div_signal), .div_stop(div_stop), .div_data(div_data),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
    .rdata(rdata), .stall(stall), .hi(hi), .lo(lo), .err_pulse(err_pulse)
  );

  typedef struct { logic err; logic [31:0] hi; logic [31:0] lo; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; int lat; } op_t;

  exp_t exp_q[$];
  op_t  op_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] hi_m = 0, lo_m = 0;   // reference HI/LO
  logic stale_hold = 1'b0;
  logic pend = 1'b0;
  logic sig_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ---------------- divider model ----------------
  // Raises stop after op.lat cycles of Signal high; stop normally falls when
  // Signal drops, but stale_hold keeps it high into the next divide, where it
  // falls on that divide's third cycle.
  op_t  cur_op;
  int   m_cnt = 0;
  logic sig_d = 1'b0;
  always @(posedge clk) begin
    sig_d <= div_signal;
    if (!div_signal) begin
      m_cnt <= 0;
      if (!stale_hold) div_stop <= 1'b0;
    end else begin
      if (!sig_d) begin
        if (op_q.size() > 0) cur_op <= op_q.pop_front();
        else                 cur_op <= '{32'd0, 32'd1, 100000};
      end
      m_cnt <= m_cnt + 1;
      if (sig_d && m_cnt + 1 == cur_op.lat) begin
        div_stop <= 1'b1;
        div_data <= {cur_op.a % cur_op.b, cur_op.a / cur_op.b};
      end else if (m_cnt + 1 == 3) begin
        div_stop <= 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      pend     = 1'b0;
      sig_prev = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result hi=%h lo=%h", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("result_kind", 32'(1'b0), 32'(e.err));
          chk("result_hi", hi, e.hi);
          chk("result_lo", lo, e.lo);
        end
      end
      if (err_pulse) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_err_pulse actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("err_kind", 32'(1'b1), 32'(e.err));
          chk("err_hi_kept", hi, e.hi);
          chk("err_lo_kept", lo, e.lo);
        end
      end else if (sig_prev && !div_signal) begin
        pend = 1'b1;
      end
      sig_prev = div_signal;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    div_start = 0; div_b_zero = 0; mthi = 0; mtlo = 0; mfhi = 0; mflo = 0;
  endtask

  // Issue a DIVU (optionally with moves), holding it until stall drops.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int lat,
                       input logic mh, input logic ml, input logic [31:0] wd);
    int g = 0;
    @(posedge clk); #1;
    div_start = 1; div_b_zero = (b == 0); mthi = mh; mtlo = ml; wdata = wd;
    @(negedge clk);
    while (stall && g < 300) begin @(negedge clk); g++; end
    if (stall) begin
      checks++; failures++;
      $display("FAIL issue_stall_timeout actual=1 required=0");
    end
    if (mh) hi_m = wd;
    if (ml) lo_m = wd;
    if (b == 0) begin
      exp_q.push_back('{1'b1, hi_m, lo_m});
    end else begin
      op_q.push_back('{a, b, lat});
      if (lat + 1 <= TIMEOUT) begin
        hi_m = a % b;
        lo_m = a / b;
        exp_q.push_back('{1'b0, hi_m, lo_m});
      end else begin
        exp_q.push_back('{1'b1, hi_m, lo_m});
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_done();
    int g = 0;
    while ((exp_q.size() != 0 || pend) && g < 300) begin @(negedge clk); g++; end
    if (exp_q.size() != 0 || pend) begin
      checks++; failures++;
      $display("FAIL wait_done_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // MTHI/MTLO/MFHI/MFLO in IDLE, with read-forwarding check.
  task automatic move(input logic mh, input logic ml, input logic [31:0] wd,
                      input logic rh, input logic rl);
    logic [31:0] r;
    @(posedge clk); #1;
    mthi = mh; mtlo = ml; wdata = wd; mfhi = rh; mflo = rl;
    r = rh ? (mh ? wd : hi_m) : rl ? (ml ? wd : lo_m) : 32'd0;
    @(negedge clk);
    chk("move_rdata", rdata, r);
    chk("move_stall", 32'(stall), 32'd0);
    if (mh) hi_m = wd;
    if (ml) lo_m = wd;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("move_hi", hi, hi_m);
    chk("move_lo", lo, lo_m);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g, n, stl;
    logic [31:0] a, b;
    reset = 0; idle_inputs(); wdata = 0; div_stop = 0; div_data = 0;
    mfhi = 1;   // any request present: stall must still be 0 in reset
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_div_signal", 32'(div_signal), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_stall", 32'(stall), 0);
    @(posedge clk); #1;
    reset = 1; mfhi = 0;

    // Moves and forwarding
    move(1, 0, 32'hDEADBEEF, 1, 0);
    move(0, 1, 32'h12345678, 0, 1);
    move(1, 1, 32'hA5A5_0001, 0, 0);
    move(0, 0, 32'h0, 1, 1);            // mfhi wins
    move(0, 0, 32'h0, 0, 1);

    // Divide by zero with HI=5
    move(1, 0, 32'd5, 0, 0);
    issue(32'd1, 32'd0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bz_div_signal", 32'(div_signal), 0);
    chk("bz_stall", 32'(stall), 0);
    wait_done();
    chk("bz_hi", hi, 32'd5);

    // DIVU 100/7, stop after 34 cycles, MFLO held during BUSY
    issue(32'd100, 32'd7, 34, 0, 0, 0);
    mflo = 1;
    g = 0; n = 0; stl = 0;
    @(negedge clk);
    while (stall && g < 300) begin
      stl++;
      if (div_signal) n++;
      @(negedge clk); g++;
    end
    chk("d100_stalled", 32'(stl > 0), 1);
    chk("d100_sig_cycles", 32'(n >= 34), 1);
    chk("d100_rdata", rdata, 32'd14);
    @(posedge clk); #1; mflo = 0;
    wait_done();
    chk("d100_hi", hi, 32'd2);
    chk("d100_lo", lo, 32'd14);

    // Divider never stops: timeout after TIMEOUT BUSY cycles
    issue(32'd55, 32'd5, 100000, 0, 0, 0);
    mfhi = 1;
    g = 0; n = 0;
    do begin
      @(negedge clk);
      if (div_signal) n++;
      g++;
    end while (!err_pulse && g < 100);
    chk("to_busy_cycles", n, TIMEOUT);
    chk("to_err", 32'(err_pulse), 1);
    chk("to_idle_nostall", 32'(stall), 0);
    @(posedge clk); #1; mfhi = 0;
    wait_done();

    // Reset in BUSY cycle 10, then DIVU 9/3
    issue(32'd1000, 32'd3, 34, 0, 0, 0);
    repeat (9) @(negedge clk);
    exp_q.delete();
    reset = 0; mflo = 1;
    #1 chk("rst_busy_stall", 32'(stall), 0);
    @(negedge clk);
    chk("rstb_div_signal", 32'(div_signal), 0);
    chk("rstb_hi", hi, 0);
    chk("rstb_lo", lo, 0);
    chk("rstb_stall", 32'(stall), 0);
    hi_m = 0; lo_m = 0;
    @(posedge clk); #1; reset = 1; mflo = 0;
    issue(32'd9, 32'd3, 8, 0, 0, 0);
    wait_done();
    chk("d9_hi", hi, 0);
    chk("d9_lo", lo, 32'd3);

    // Back-to-back 10/3 then 20/6 (second held by stall)
    issue(32'd10, 32'd3, 6, 0, 0, 0);
    issue(32'd20, 32'd6, 7, 0, 0, 0);
    chk("b2b_first_hi", hi, 32'd1);
    chk("b2b_first_lo", lo, 32'd3);
    @(negedge clk);
    chk("b2b_second_busy", 32'(div_signal), 1);
    wait_done();
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd3);

    // Move in the same cycle as DIVU: move first, result overwrites later
    issue(32'd45, 32'd6, 10, 1, 0, 32'hCAFE_F00D);
    @(negedge clk);
    chk("mv_div_hi_early", hi, 32'hCAFE_F00D);
    wait_done();

    // Stale stop flag carried into the next divide
    stale_hold = 1;
    issue(32'd50, 32'd8, 5, 0, 0, 0);
    wait_done();
    issue(32'd77, 32'd10, 12, 0, 0, 0);
    stale_hold = 0;
    wait_done();
    chk("stale_hi", hi, 32'd7);
    chk("stale_lo", lo, 32'd7);

    // Randomized moves and divides
    for (int i = 0; i < 16; i++) begin
      move(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom | 32'd1);
      issue(a, b, $urandom_range(4, 30), 1'($urandom), 1'($urandom), $urandom);
      wait_done();
      chk("rnd_hi", hi, hi_m);
      chk("rnd_lo", lo, lo_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 40, giving the maximum number of BUSY cycles allowed before a divide is aborted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-004 The block SHALL have port div_start, input, 1 bit: DIVU issued by EX this cycle.
REQ-005 The block SHALL have port div_b_zero, input, 1 bit: divisor of the issuing DIVU is zero; sampled with div_start.
REQ-006 The block SHALL have port div_signal, output, 1 bit: level drive to the divider Signal input.
REQ-007 The block SHALL have port div_stop, input, 1 bit: divider stop flag.
REQ-008 The block SHALL have port div_data, input, 64 bits: divider result, [63:32] remainder and [31:0] quotient.
REQ-009 The block SHALL have ports mthi and mtlo, input, 1 bit each: write HI or LO from wdata.
REQ-010 The block SHALL have port wdata, input, 32 bits: MTHI/MTLO source.
REQ-011 The block SHALL have ports mfhi and mflo, input, 1 bit each: read request.
REQ-012 The block SHALL have port rdata, output, 32 bits: MFHI/MFLO result.
REQ-013 The block SHALL have port stall, output, 1 bit: freeze IF/ID/EX this cycle.
REQ-014 The block SHALL have ports hi and lo, output, 32 bits each: architectural HI and LO.
REQ-015 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse on divide-by-zero or timeout.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-017 In IDLE, div_start=1 with div_b_zero=0 SHALL move the FSM to BUSY, set div_signal=1 and clear the timeout counter, all on the next edge.
REQ-018 In IDLE, div_start=1 with div_b_zero=1 SHALL keep the FSM in IDLE, leave HI and LO unchanged, and pulse err_pulse for one cycle.
REQ-019 In BUSY, div_signal SHALL be held at 1 and the timeout counter SHALL increment by 1 each cycle.
REQ-020 In BUSY, div_stop=1 SHALL move the FSM to DONE and capture div_data into an internal 64-bit holding register.
REQ-021 In BUSY, reaching a count of TIMEOUT with div_stop=0 SHALL move the FSM to IDLE, drop div_signal, pulse err_pulse and leave HI and LO unchanged.
REQ-022 In DONE, the block SHALL set div_signal=0, load HI from holding[63:32] and LO from holding[31:0], and return to IDLE on the next edge.
REQ-023 div_signal SHALL be 0 in every state other than BUSY, so that the divider re-arms before the next DIVU.
REQ-024 stall SHALL be combinational: stall = (div_start|mthi|mtlo|mfhi|mflo) and state != IDLE.
REQ-025 An instruction held by stall SHALL have no effect until the cycle in which stall=0.
REQ-026 In IDLE, mthi SHALL write HI and mtlo SHALL write LO on the next edge; both asserted SHALL write both.
REQ-027 rdata SHALL be combinational: mfhi selects HI and mflo selects LO, mfhi wins if both are set, otherwise rdata=0.
REQ-028 rdata SHALL forward wdata when a same-cycle mthi (with mfhi) or mtlo (with mflo) is present.
REQ-029 In IDLE, div_start together with mthi or mtlo in the same cycle SHALL give priority to the move; the divide result SHALL overwrite HI/LO later in DONE.
REQ-030 A div_stop already high on the first BUSY cycle (stale flag from a prior divide) SHALL be ignored; capture SHALL occur only on a 0-to-1 transition of div_stop seen in BUSY.
REQ-031 Latency SHALL be: the divide result is visible on hi/lo two cycles after the div_stop rising edge is sampled.

Reset
REQ-032 While reset=0 at a clock edge, the block SHALL force state to IDLE and clear hi, lo, the holding register and the timeout counter to 0.
REQ-033 While reset=0 at a clock edge, the block SHALL set div_signal=0 and err_pulse=0.
REQ-034 Reset asserted mid-BUSY SHALL abort the divide with no HI/LO update.
REQ-035 stall SHALL be 0 during and after reset, until a new divide begins.

Verification
REQ-036 DIVU 100/7, with a divider model giving stop after 34 cycles -> div_signal=1 for 34+ cycles, then hi=2, lo=14; mflo issued during BUSY -> stall=1 until IDLE, then rdata=14.
REQ-037 div_start with div_b_zero=1 and HI=5 -> err_pulse for one cycle, hi stays 5, div_signal stays 0, stall=0.
REQ-038 Divider model that never raises stop -> after 40 BUSY cycles err_pulse=1, state IDLE, hi/lo unchanged.
REQ-039 In IDLE, mthi with wdata=0xDEADBEEF and mfhi in the same cycle -> rdata=0xDEADBEEF; the next cycle hi=0xDEADBEEF.
REQ-040 Reset=0 asserted at BUSY cycle 10 -> next cycle div_signal=0, hi=lo=0, stall=0; a following DIVU 9/3 -> hi=0, lo=3.
REQ-041 Back-to-back DIVU 10/3 then 20/6 with the second held by stall -> second Signal rises only after DONE; final hi=2, lo=3.
